// File: rtl/dsdc_control_if.sv
// ---------------------------------------------------------------------------
// dsdc_control_if
//   Handshake bundle between the decrypt/decompress sequencer and its
//   surroundings (upstream source, decryption core, decompression core,
//   downstream sink, and the error/status observer).
//
//   master : environment side. It drives key_config, in_valid, decry_done,
//            decomp_rdy, decomp_done, decomp_last, out_rcvd and clear_err.
//   slave  : controller side. It drives rdy, valid_to_decry, valid_to_decomp,
//            decomp_hold, out_valid, stall, error, error_code, words_in and
//            words_out.
// ---------------------------------------------------------------------------
interface dsdc_control_if #(
  parameter int CNT_W = 16
);
  logic             key_config;
  logic             in_valid;
  logic             rdy;
  logic             valid_to_decry;
  logic             decry_done;
  logic             valid_to_decomp;
  logic             decomp_rdy;
  logic             decomp_done;
  logic             decomp_last;
  logic             decomp_hold;
  logic             out_valid;
  logic             out_rcvd;
  logic             stall;
  logic             error;
  logic [7:0]       error_code;
  logic             clear_err;
  logic [CNT_W-1:0] words_in;
  logic [CNT_W-1:0] words_out;

  modport master (
    output key_config, in_valid, decry_done, decomp_rdy, decomp_done,
           decomp_last, out_rcvd, clear_err,
    input  rdy, valid_to_decry, valid_to_decomp, decomp_hold, out_valid,
           stall, error, error_code, words_in, words_out
  );

  modport slave (
    input  key_config, in_valid, decry_done, decomp_rdy, decomp_done,
           decomp_last, out_rcvd, clear_err,
    output rdy, valid_to_decry, valid_to_decomp, decomp_hold, out_valid,
           stall, error, error_code, words_in, words_out
  );
endinterface

// File: rtl/dsdc_control.sv
// ---------------------------------------------------------------------------
// dsdc_control
//   Sequencer for one encrypted 64-bit word at a time. The word is accepted
//   in IDLE, handed to the decryption core (DECRYPT, watchdog-timed), offered
//   to the decompression core (FEED), and the decompressed output words are
//   delivered downstream one by one (DRAIN) until the word flagged last is
//   taken. Protocol violations park the block in ERR until clear_err.
//
//   Ports
//     clk  : single clock, all state on the rising edge
//     rst  : synchronous, active-high reset
//     bus  : dsdc_control_if.slave handshake/status bundle
//   Parameters
//     TIMEOUT : cycles allowed in DECRYPT before a timeout error
//     CNT_W   : width of the saturating word counters
// ---------------------------------------------------------------------------
module dsdc_control #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic           clk,
  input  logic           rst,
  dsdc_control_if.slave  bus
);
  localparam int         TMR_W        = $clog2(TIMEOUT + 1);
  localparam logic [7:0] ERR_PROTOCOL = 8'h01;
  localparam logic [7:0] ERR_TIMEOUT  = 8'h02;
  localparam logic [7:0] ERR_OVERRUN  = 8'h03;

  typedef enum logic [2:0] {IDLE, KEYCFG, DECRYPT, FEED, DRAIN, ERR} state_t;

  state_t           state_reg, state_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic             out_valid_reg, out_valid_next;
  logic             last_reg, last_next;          // current output word is the final one
  logic [7:0]       error_code_reg, error_code_next;
  logic [CNT_W-1:0] words_in_reg, words_in_next;
  logic [CNT_W-1:0] words_out_reg, words_out_next;

  logic       accept;
  logic       retire;
  logic       err_hit;
  logic [7:0] err_code;
  logic       error_w;

  assign accept  = (state_reg == IDLE) && bus.in_valid && !bus.key_config;
  assign retire  = out_valid_reg && bus.out_rcvd;
  assign error_w = (state_reg == ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      out_valid_reg  <= 1'b0;
      last_reg       <= 1'b0;
      error_code_reg <= 8'h00;
      words_in_reg   <= '0;
      words_out_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      out_valid_reg  <= out_valid_next;
      last_reg       <= last_next;
      error_code_reg <= error_code_next;
      words_in_reg   <= words_in_next;
      words_out_reg  <= words_out_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    timer_next      = timer_reg;
    out_valid_next  = out_valid_reg;
    last_next       = last_reg;
    error_code_next = error_code_reg;
    words_in_next   = words_in_reg;
    words_out_next  = words_out_reg;
    err_hit         = 1'b0;
    err_code        = 8'h00;

    // Counters stick at all-ones instead of wrapping.
    if (accept && (words_in_reg != '1))
      words_in_next = words_in_reg + CNT_W'(1);
    if (retire && (words_out_reg != '1))
      words_out_next = words_out_reg + CNT_W'(1);

    // Error checks are ordered so the lowest code wins when several fire.
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = DECRYPT;
          timer_next = '0;
        end
      end
      KEYCFG: begin
        if (!bus.key_config)
          state_next = IDLE;
      end
      DECRYPT: begin
        if (bus.in_valid) begin
          err_hit  = 1'b1;
          err_code = ERR_PROTOCOL;
        end else if (bus.decry_done) begin
          state_next = FEED;
        end else if (timer_reg == TMR_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th cycle spent here without a result.
          err_hit  = 1'b1;
          err_code = ERR_TIMEOUT;
        end else begin
          timer_next = timer_reg + TMR_W'(1);
        end
      end
      FEED: begin
        if (bus.in_valid) begin
          err_hit  = 1'b1;
          err_code = ERR_PROTOCOL;
        end else if (bus.decomp_rdy) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.in_valid) begin
          err_hit  = 1'b1;
          err_code = ERR_PROTOCOL;
        end else if (bus.decomp_done && out_valid_reg && !bus.out_rcvd) begin
          err_hit  = 1'b1;
          err_code = ERR_OVERRUN;
        end else if (bus.decomp_done) begin
          // A new word may replace one being retired in the same cycle.
          out_valid_next = 1'b1;
          last_next      = bus.decomp_last;
        end else if (retire) begin
          out_valid_next = 1'b0;
          if (last_reg) begin
            last_next  = 1'b0;
            state_next = IDLE;
          end
        end
      end
      ERR: begin
        if (bus.clear_err)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Key configuration pre-empts everything except ERR and drops the
    // in-flight word without raising an error.
    if (bus.key_config && (state_reg != ERR)) begin
      state_next     = KEYCFG;
      out_valid_next = 1'b0;
      last_next      = 1'b0;
    end else if (err_hit) begin
      state_next      = ERR;
      error_code_next = err_code;
      out_valid_next  = 1'b0;
      last_next       = 1'b0;
    end
  end

  assign bus.rdy             = (state_reg == IDLE) && !bus.key_config;
  assign bus.valid_to_decry  = accept;
  assign bus.valid_to_decomp = (state_reg == FEED);
  assign bus.out_valid       = out_valid_reg;
  assign bus.decomp_hold     = out_valid_reg && !bus.out_rcvd;
  assign bus.error           = error_w;
  assign bus.stall           = bus.key_config || error_w;
  assign bus.error_code      = error_code_reg;
  assign bus.words_in        = words_in_reg;
  assign bus.words_out       = words_out_reg;
endmodule

// File: tb/tb_dsdc_control.sv
// ---------------------------------------------------------------------------
// tb_dsdc_control
//   Cycle-by-cycle bench for dsdc_control. Each step drives one cycle of
//   inputs, queues the expected outputs for that cycle, and compares them at
//   the falling edge. Narrow counters (CNT_W=4) make saturation reachable.
//
//   Input vector bits  : {key_config, in_valid, decry_done, decomp_rdy,
//                         decomp_done, decomp_last, out_rcvd, clear_err}
//   Output flag bits   : {rdy, valid_to_decry, valid_to_decomp, out_valid,
//                         decomp_hold, stall, error}
// ---------------------------------------------------------------------------
module tb_dsdc_control;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 64;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int OW      = 7 + 8 + 2 * CNT_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dsdc_control_if #(.CNT_W(CNT_W)) bus();

  dsdc_control #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [7:0] in;
    logic [6:0] flags;
    logic [7:0] code;
    int         wi;
    int         wo;
  } vec_t;

  vec_t       tbl[$];
  vec_t       sb_q[$];
  int         n_cmp  = 0;
  int         n_err  = 0;
  int         exp_wi = 0;
  int         exp_wo = 0;
  logic [7:0] exp_code = 8'h00;

  function automatic vec_t mk(logic [7:0] i, logic [6:0] f, logic [7:0] c,
                              int wi, int wo);
    vec_t v;
    v.in = i; v.flags = f; v.code = c; v.wi = wi; v.wo = wo;
    return v;
  endfunction

  function automatic int sat(int x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  task automatic drive(input logic [7:0] i);
    {bus.key_config, bus.in_valid, bus.decry_done, bus.decomp_rdy,
     bus.decomp_done, bus.decomp_last, bus.out_rcvd, bus.clear_err} = i;
  endtask

  // One clock cycle: drive, queue expectation, compare mid-cycle.
  task automatic step(input string name, input vec_t v);
    vec_t          e;
    logic [OW-1:0] act;
    logic [OW-1:0] expv;
    drive(v.in);
    sb_q.push_back(v);
    @(negedge clk);
    e    = sb_q.pop_front();
    act  = {bus.rdy, bus.valid_to_decry, bus.valid_to_decomp, bus.out_valid,
            bus.decomp_hold, bus.stall, bus.error, bus.error_code,
            bus.words_in, bus.words_out};
    expv = {e.flags, e.code, CNT_W'(e.wi), CNT_W'(e.wo)};
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h want %h (flags/code/wi/wo)", name, act, expv);
    end else begin
      $display("ok   %s: %h", name, act);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] i, input logic [6:0] f);
    step(name, mk(i, f, exp_code, exp_wi, exp_wo));
  endtask

  // Shortest legal transaction with a single output word.
  task automatic fast_txn(input string name);
    chk({name, "_acc"}, 8'b0100_0000, 7'b1100000);
    exp_wi = sat(exp_wi);
    chk({name, "_dd"},  8'b0010_0000, 7'b0000000);
    chk({name, "_dr"},  8'b0001_0000, 7'b0010000);
    chk({name, "_dn"},  8'b0000_1100, 7'b0000000);
    chk({name, "_rc"},  8'b0000_0010, 7'b0001000);
    exp_wo = sat(exp_wo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    // Keycfg in IDLE, then the normal single-word transaction.
    tbl.push_back(mk(8'b0000_0000, 7'b1000000, 8'h00, 0, 0));
    tbl.push_back(mk(8'b1100_0000, 7'b0000010, 8'h00, 0, 0));
    tbl.push_back(mk(8'b0000_0000, 7'b0000000, 8'h00, 0, 0));
    tbl.push_back(mk(8'b0100_0000, 7'b1100000, 8'h00, 0, 0));
    tbl.push_back(mk(8'b0000_0000, 7'b0000000, 8'h00, 1, 0));
    tbl.push_back(mk(8'b0000_0000, 7'b0000000, 8'h00, 1, 0));
    tbl.push_back(mk(8'b0010_0000, 7'b0000000, 8'h00, 1, 0));
    tbl.push_back(mk(8'b0000_0000, 7'b0010000, 8'h00, 1, 0));
    tbl.push_back(mk(8'b0001_0000, 7'b0010000, 8'h00, 1, 0));
    tbl.push_back(mk(8'b0000_1100, 7'b0000000, 8'h00, 1, 0));
    tbl.push_back(mk(8'b0000_0000, 7'b0001100, 8'h00, 1, 0));
    tbl.push_back(mk(8'b0000_0010, 7'b0001000, 8'h00, 1, 0));
    tbl.push_back(mk(8'b0000_0000, 7'b1000000, 8'h00, 1, 1));
    // Two output words; the second arrives as the first is taken.
    tbl.push_back(mk(8'b0100_0000, 7'b1100000, 8'h00, 1, 1));
    tbl.push_back(mk(8'b0010_0000, 7'b0000000, 8'h00, 2, 1));
    tbl.push_back(mk(8'b0001_0000, 7'b0010000, 8'h00, 2, 1));
    tbl.push_back(mk(8'b0000_1000, 7'b0000000, 8'h00, 2, 1));
    tbl.push_back(mk(8'b0000_1110, 7'b0001000, 8'h00, 2, 1));
    tbl.push_back(mk(8'b0000_0000, 7'b0001100, 8'h00, 2, 2));
    tbl.push_back(mk(8'b0000_0010, 7'b0001000, 8'h00, 2, 2));
    tbl.push_back(mk(8'b0000_0000, 7'b1000000, 8'h00, 2, 3));

    drive(8'h00);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("tbl%0d", i), tbl[i]);
    exp_wi = 2;
    exp_wo = 3;

    // Decrypt timeout: 64 quiet cycles in DECRYPT, then ERR.
    chk("to_acc", 8'b0100_0000, 7'b1100000);
    exp_wi = sat(exp_wi);
    for (int k = 0; k < TIMEOUT; k++)
      chk($sformatf("to_wait%0d", k), 8'b0000_0000, 7'b0000000);
    exp_code = 8'h02;
    chk("to_err_kc", 8'b1000_0000, 7'b0000011);
    chk("to_err",    8'b0000_0000, 7'b0000011);
    chk("to_clr",    8'b0000_0001, 7'b0000011);
    chk("to_idle",   8'b0000_0000, 7'b1000000);

    // Output overrun: second decomp_done while the first word waits.
    chk("ov_acc", 8'b0100_0000, 7'b1100000);
    exp_wi = sat(exp_wi);
    chk("ov_dd",   8'b0010_0000, 7'b0000000);
    chk("ov_dr",   8'b0001_0000, 7'b0010000);
    chk("ov_dn1",  8'b0000_1000, 7'b0000000);
    chk("ov_hold", 8'b0000_0000, 7'b0001100);
    chk("ov_dn2",  8'b0000_1000, 7'b0001100);
    exp_code = 8'h03;
    chk("ov_err",  8'b0000_0000, 7'b0000011);
    chk("ov_clr",  8'b0000_0001, 7'b0000011);
    chk("ov_idle", 8'b0000_0000, 7'b1000000);

    // Key configuration while decrypting drops the word, no error.
    chk("kc_acc", 8'b0100_0000, 7'b1100000);
    exp_wi = sat(exp_wi);
    chk("kc_dec",  8'b1100_0000, 7'b0000010);
    chk("kc_hold", 8'b1100_0000, 7'b0000010);
    chk("kc_rel",  8'b0000_0000, 7'b0000000);
    chk("kc_idle", 8'b0000_0000, 7'b1000000);

    // Protocol error in FEED, then reset clears everything.
    chk("pe_acc", 8'b0100_0000, 7'b1100000);
    exp_wi = sat(exp_wi);
    chk("pe_dd",   8'b0010_0000, 7'b0000000);
    chk("pe_feed", 8'b0100_0000, 7'b0010000);
    exp_code = 8'h01;
    chk("pe_err",  8'b0000_0000, 7'b0000011);
    drive(8'h00);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_code = 8'h00;
    exp_wi   = 0;
    exp_wo   = 0;
    chk("rst_idle", 8'b0000_0000, 7'b1000000);

    // Run past counter saturation.
    for (int n = 0; n < CMAX + 2; n++)
      fast_txn($sformatf("sat%0d", n));
    chk("sat_idle", 8'b0000_0000, 7'b1000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
